// File: rtl/bus_arbiter_pkg.sv
// Shared types for the round-robin bus arbiter slice.
package bus_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin winner search: first asserted request at or after ptr, wrapping.
module rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  int idx;

  // Walk N slots from ptr; the first hit is kept, later hits are ignored.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared data bus feeding a bus-loaded register,
// with lock-extended grants bounded by MAX_HOLD cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int REQ_COUNT = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_HOLD  = 8,
  parameter int IDX_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1,
  parameter int HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [REQ_COUNT-1:0]       req,
  input  logic [REQ_COUNT-1:0]       lock,
  input  logic [WIDTH*REQ_COUNT-1:0] req_data,
  output logic [REQ_COUNT-1:0]       grant,
  output logic [IDX_W-1:0]           grant_idx,
  output logic                       busy,
  output logic [WIDTH-1:0]           bus_data,
  output logic                       bus_load,
  output logic                       timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(REQ_COUNT - 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     next_ptr;
  logic [IDX_W-1:0]     sel_ptr;
  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic                 locked;
  logic                 extend;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [REQ_COUNT-1:0] win_onehot;

  // A release searches from the slot after the current owner, so the
  // re-arbitration in the release cycle already sees the advanced pointer.
  assign next_ptr = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
  assign sel_ptr  = (state == ARB_GRANT) ? next_ptr : ptr;

  rr_select #(
    .N     (REQ_COUNT),
    .IDX_W (IDX_W)
  ) u_sel (
    .req    (req),
    .ptr    (sel_ptr),
    .winner (winner),
    .found  (found)
  );

  assign locked   = (state == ARB_GRANT) && req[grant_idx] && lock[grant_idx];
  assign extend   = locked && (hold_cnt < HOLD_LAST);
  assign timeout  = locked && (hold_cnt == HOLD_LAST);
  assign busy     = (state == ARB_GRANT);
  assign bus_load = |(grant & req);

  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
  end

  always_comb begin
    bus_data = '0;
    if (busy) bus_data = req_data[int'(grant_idx)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            state     <= ARB_GRANT;
            grant     <= win_onehot;
            grant_idx <= winner;
            hold_cnt  <= '0;
          end
        end
        ARB_GRANT: begin
          if (extend) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            ptr      <= next_ptr;
            hold_cnt <= '0;
            if (found) begin
              grant     <= win_onehot;
              grant_idx <= winner;
            end else begin
              state     <= ARB_IDLE;
              grant     <= '0;
              grant_idx <= '0;
            end
          end
        end
        default: begin
          state     <= ARB_IDLE;
          grant     <= '0;
          grant_idx <= '0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected grant cycles,
// a negedge monitor pops and compares whenever the arbiter holds a grant.
module tb_bus_arbiter;

  localparam int REQ_COUNT = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_HOLD  = 8;
  localparam int IDX_W     = 2;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] idx;
    logic [7:0] data;
    logic       load;
    logic       to;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        busy;
  logic [7:0]  bus_data;
  logic        bus_load;
  logic        timeout;

  exp_t        exp_q[$];
  string       name_q[$];
  logic [7:0]  byte_tab[4] = '{8'hB0, 8'hC1, 8'hA5, 8'hD3};
  int          errors = 0;
  int          checks = 0;

  bus_arbiter #(
    .REQ_COUNT (REQ_COUNT),
    .WIDTH     (WIDTH),
    .MAX_HOLD  (MAX_HOLD),
    .IDX_W     (IDX_W),
    .HOLD_W    (3)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req       (req),
    .lock      (lock),
    .req_data  (req_data),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .bus_data  (bus_data),
    .bus_load  (bus_load),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Any cycle with an active grant must match the next queued expectation.
  initial begin : monitor
    exp_t  e;
    exp_t  got;
    string nm;
    forever begin
      @(negedge clk);
      if (busy || (grant != 4'b0000)) begin
        checks++;
        got = {grant, grant_idx, bus_data, bus_load, timeout};
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_grant: got grant=%b idx=%0d data=%h load=%b timeout=%b busy=%b, required no grant",
                   grant, grant_idx, bus_data, bus_load, timeout, busy);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (got !== e || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: got grant=%b idx=%0d data=%h load=%b timeout=%b busy=%b, required grant=%b idx=%0d data=%h load=%b timeout=%b busy=1",
                     nm, grant, grant_idx, bus_data, bus_load, timeout, busy,
                     e.grant, e.idx, e.data, e.load, e.to);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name);
    checks++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || busy !== 1'b0 ||
        bus_data !== 8'h00 || bus_load !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b idx=%0d busy=%b data=%h load=%b timeout=%b, required all zero",
               name, grant, grant_idx, busy, bus_data, bus_load, timeout);
    end
  endtask

  // One clock cycle of inputs; g is the requester expected to hold the grant.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l,
                               input logic exp_busy, input int g,
                               input logic eto, input string name);
    exp_t e;
    req  = r;
    lock = l;
    if (exp_busy) begin
      e.grant = 4'b0001 << g;
      e.idx   = 2'(g);
      e.data  = byte_tab[g];
      e.load  = r[g];
      e.to    = eto;
      exp_q.push_back(e);
      name_q.push_back(name);
    end
    @(negedge clk);
    if (!exp_busy) checkOutput(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst     = 1'b0;
    req      = 4'b0000;
    lock     = 4'b0000;
    req_data = {byte_tab[3], byte_tab[2], byte_tab[1], byte_tab[0]};
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state");
    nrst = 1'b1;

    $display("[TB] fairness");
    applyStimulus(4'b1111, 4'b0000, 1'b0, 0, 1'b0, "fair_idle");
    applyStimulus(4'b1111, 4'b0000, 1'b1, 0, 1'b0, "fair_g0");
    applyStimulus(4'b1111, 4'b0000, 1'b1, 1, 1'b0, "fair_g1");
    applyStimulus(4'b1111, 4'b0000, 1'b1, 2, 1'b0, "fair_g2");
    applyStimulus(4'b1111, 4'b0000, 1'b1, 3, 1'b0, "fair_g3");
    applyStimulus(4'b1111, 4'b0000, 1'b1, 0, 1'b0, "fair_wrap_g0");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1, 1'b0, "fair_last_g1");
    applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 1'b0, "fair_end_idle");

    $display("[TB] single request");
    applyStimulus(4'b0100, 4'b0000, 1'b0, 0, 1'b0, "single_idle");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 2, 1'b0, "single_g2_noload");
    applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 1'b0, "single_end_idle");

    $display("[TB] lock with timeout");
    applyStimulus(4'b0010, 4'b0010, 1'b0, 0, 1'b0, "to_idle");
    for (int k = 0; k < MAX_HOLD - 1; k++)
      applyStimulus(4'b1010, 4'b0010, 1'b1, 1, 1'b0, "to_hold");
    applyStimulus(4'b1010, 4'b0010, 1'b1, 1, 1'b1, "to_final");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 3, 1'b0, "to_next_g3");
    applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 1'b0, "to_end_idle");

    $display("[TB] lock early end");
    applyStimulus(4'b1010, 4'b0010, 1'b0, 0, 1'b0, "early_idle");
    for (int k = 0; k < 3; k++)
      applyStimulus(4'b1010, 4'b0010, 1'b1, 1, 1'b0, "early_hold");
    applyStimulus(4'b1010, 4'b0000, 1'b1, 1, 1'b0, "early_unlock");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 3, 1'b0, "early_next_g3");
    applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 1'b0, "early_end_idle");

    $display("[TB] request drop under lock");
    applyStimulus(4'b0010, 4'b0010, 1'b0, 0, 1'b0, "drop_idle");
    applyStimulus(4'b0010, 4'b0010, 1'b1, 1, 1'b0, "drop_c1");
    applyStimulus(4'b0000, 4'b0010, 1'b1, 1, 1'b0, "drop_c2_noload");
    applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 1'b0, "drop_end_idle");

    $display("[TB] async reset mid-grant");
    applyStimulus(4'b0100, 4'b0100, 1'b0, 0, 1'b0, "rst_pre_idle");
    applyStimulus(4'b0100, 4'b0100, 1'b1, 2, 1'b0, "rst_pre_g2");
    #1;
    nrst = 1'b0;
    #1;
    checkOutput("async_reset_drop");
    @(posedge clk);
    #1;
    nrst = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 1'b0, 0, 1'b0, "post_rst_idle");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 0, 1'b0, "post_rst_g0");
    applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 1'b0, "post_rst_end_idle");

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_grants: got %0d expected grant cycles never seen, required 0",
               exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
